// File: rtl/registro_pkg.sv
// Shared constants and helpers for the registro_retardo delay line.
package registro_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/registro_retardo_if.sv
// Sample-stream bundle for registro_retardo; suma exists only with REGISTRO_RETARDO_SUMA_EN.
interface registro_retardo_if
    import registro_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int NW = clog2(DEPTH + 1);
    localparam int SW = WIDTH + clog2(DEPTH);

    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] datoIn;
    logic [WIDTH-1:0] datoOut;
    logic             valid;
    logic [NW-1:0]    nivel;
`ifdef REGISTRO_RETARDO_SUMA_EN
    logic [SW-1:0]    suma;

    modport master (output enable, clear, datoIn, input datoOut, valid, nivel, suma);
    modport slave  (input enable, clear, datoIn, output datoOut, valid, nivel, suma);
`else
    modport master (output enable, clear, datoIn, input datoOut, valid, nivel);
    modport slave  (input enable, clear, datoIn, output datoOut, valid, nivel);
`endif
endinterface

// File: rtl/registro_etapa.sv
// One delay stage: WIDTH-bit register with load enable, flush and synchronous active-low reset.
module registro_etapa #(
    parameter int WIDTH = 8
) (
    input  logic             clk44kHz,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk44kHz) begin
        if (!reset)      q <= '0;
        else if (clear)  q <= '0;
        else if (enable) q <= d;
    end
endmodule

// File: rtl/registro_retardo.sv
// Strobe-driven delay line of DEPTH registered stages with fill count and valid flag.
// Define REGISTRO_RETARDO_SUMA_EN to add the running-sum output suma.
module registro_retardo
    import registro_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk44kHz,
    input  logic               reset,
    registro_retardo_if.slave  bus
);
    localparam int NW = clog2(DEPTH + 1);
    localparam int SW = WIDTH + clog2(DEPTH);
    localparam logic [NW-1:0] FULL = NW'(DEPTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_param
        $error("registro_retardo: WIDTH/DEPTH out of legal range");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [NW-1:0]               nivel;
    logic [NW-1:0]               nivel_next;
    logic                        valid;

    assign stage_d[0] = bus.datoIn;
    for (genvar k = 0; k < DEPTH; k++) begin : g_etapa
        if (k > 0) begin : g_link
            assign stage_d[k] = stage[k-1];
        end
        registro_etapa #(.WIDTH(WIDTH)) u_etapa (
            .clk44kHz (clk44kHz),
            .reset    (reset),
            .clear    (bus.clear),
            .enable   (bus.enable),
            .d        (stage_d[k]),
            .q        (stage[k])
        );
    end

    // Count saturates at DEPTH; valid is registered from the same next value.
    always_comb begin
        nivel_next = nivel;
        if (bus.enable && nivel != FULL) nivel_next = nivel + 1'b1;
    end

    always_ff @(posedge clk44kHz) begin
        if (!reset || bus.clear) begin
            nivel <= '0;
            valid <= 1'b0;
        end else if (bus.enable) begin
            nivel <= nivel_next;
            valid <= (nivel_next == FULL);
        end
    end

    assign bus.datoOut = stage[DEPTH-1];
    assign bus.nivel   = nivel;
    assign bus.valid   = valid;

`ifdef REGISTRO_RETARDO_SUMA_EN
    logic [SW-1:0] suma;

    // The leaving sample is always <= suma, so the modular update stays exact.
    always_ff @(posedge clk44kHz) begin
        if (!reset || bus.clear) suma <= '0;
        else if (bus.enable)     suma <= suma + SW'(bus.datoIn) - SW'(stage[DEPTH-1]);
    end

    assign bus.suma = suma;
`endif
endmodule

// File: tb/tb_registro_retardo.sv
// Self-checking bench for registro_retardo: directed scenarios plus random traffic vs a queue model.
module tb_registro_retardo;
    import registro_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NW = clog2(D + 1);

    logic clk44kHz = 1'b0;
    logic reset;
    int   checks = 0;
    int   errs   = 0;

    // Model: newest sample at index 0, oldest at index D-1.
    int unsigned mq[$];
    int unsigned mcnt;

    registro_retardo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    registro_retardo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #5 clk44kHz = ~clk44kHz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_flush();
        mq = {};
        for (int i = 0; i < D; i++) mq.push_back(0);
        mcnt = 0;
    endtask

    task automatic check_all(input string tag);
        int unsigned s;
        s = 0;
        foreach (mq[i]) s += mq[i];
        chk({tag, ".datoOut"}, 64'(bus.datoOut), 64'(mq[D-1]));
        chk({tag, ".nivel"},   64'(bus.nivel),   64'(mcnt));
        chk({tag, ".valid"},   64'(bus.valid),   64'(mcnt == D));
`ifdef REGISTRO_RETARDO_SUMA_EN
        chk({tag, ".suma"},    64'(bus.suma),    64'(s));
`endif
    endtask

    task automatic tick(input string tag, input logic rst, input logic en, input logic clr,
                        input logic [W-1:0] d);
        reset      = rst;
        bus.enable = en;
        bus.clear  = clr;
        bus.datoIn = d;
        @(posedge clk44kHz);
        if (!rst || clr) model_flush();
        else if (en) begin
            mq.push_front(int'(d));
            void'(mq.pop_back());
            if (mcnt < D) mcnt++;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b0; bus.clear = 1'b0; bus.datoIn = '0;
        model_flush();

        // Reset fill
        tick("rst0", 1'b0, 1'b0, 1'b0, 8'h00);
        tick("rst1", 1'b0, 1'b1, 1'b0, 8'hAA);
        chk("rst.nivel0", 64'(bus.nivel), 64'(0));
        tick("fill1", 1'b1, 1'b1, 1'b0, 8'h11);
        tick("fill2", 1'b1, 1'b1, 1'b0, 8'h22);
        tick("fill3", 1'b1, 1'b1, 1'b0, 8'h33);
        chk("fill3.valid_low", 64'(bus.valid), 64'(0));
        tick("fill4", 1'b1, 1'b1, 1'b0, 8'h44);
        chk("fill4.out11", 64'(bus.datoOut), 64'h11);
        chk("fill4.valid", 64'(bus.valid), 64'(1));
        chk("fill4.nivel", 64'(bus.nivel), 64'(4));

        // Hold
        for (int i = 0; i < 10; i++) tick("hold", 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("hold.out11", 64'(bus.datoOut), 64'h11);

        // Stream and saturation
        tick("strm1", 1'b1, 1'b1, 1'b0, 8'h55);
        chk("strm1.out22", 64'(bus.datoOut), 64'h22);
        tick("strm2", 1'b1, 1'b1, 1'b0, 8'h66);
        chk("strm2.out33", 64'(bus.datoOut), 64'h33);
        chk("strm2.nivel", 64'(bus.nivel), 64'(4));

        // Clear wins over enable
        tick("clr", 1'b1, 1'b1, 1'b1, 8'h99);
        chk("clr.nivel0", 64'(bus.nivel), 64'(0));
        tick("clr.next", 1'b1, 1'b1, 1'b0, 8'h77);
        chk("clr.next.nivel1", 64'(bus.nivel), 64'(1));
        chk("clr.next.out0", 64'(bus.datoOut), 64'(0));

        // Mid-fill reset
        tick("mf1", 1'b1, 1'b1, 1'b0, 8'hA1);
        tick("mfrst", 1'b0, 1'b1, 1'b1, 8'hA2);
        chk("mfrst.nivel0", 64'(bus.nivel), 64'(0));
        for (int i = 0; i < 3; i++) tick("refill", 1'b1, 1'b1, 1'b0, 8'(8'hB0 + i));
        chk("refill3.valid_low", 64'(bus.valid), 64'(0));
        tick("refill4", 1'b1, 1'b1, 1'b0, 8'hB3);
        chk("refill4.outB0", 64'(bus.datoOut), 64'hB0);

`ifdef REGISTRO_RETARDO_SUMA_EN
        tick("sclr", 1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            tick("sff", 1'b1, 1'b1, 1'b0, 8'hFF);
            if (i >= 4) chk("sum.3fc", 64'(bus.suma), 64'h3FC);
        end
        tick("s00", 1'b1, 1'b1, 1'b0, 8'h00);
        chk("sum.2fd", 64'(bus.suma), 64'h2FD);
        tick("sclr2", 1'b1, 1'b0, 1'b1, 8'h00);
        chk("sum.clr", 64'(bus.suma), 64'(0));
`endif

        // Random traffic with idle gaps, rare clears and resets
        for (int i = 0; i < 400; i++) begin
            logic r, e, c;
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 29) == 0);
            tick("rand", r, e, c, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
